bsg_link_credit_upstream: RTL and testbench
===========================================

// Module: bsg_link_credit_upstream
// PURPOSE
//  Core-side transmit stage feeding bsg_link_ddr_downstream: accepts CORE_W words (valid/ready),
//  serialises each into CORE_W/CHANNEL_W phits, LSB phit first, and drives them onto the link.
//  Credit-based flow control: one credit per phit. Credits are returned by toggles of the
//  downstream token line (core_token_r_o), each toggle worth TOKEN_DECIMATION credits.
// PARAMETERS
//  CORE_W            32  core word width; must be an integer multiple of CHANNEL_W
//  CHANNEL_W         16  phit width (one downstream buffer entry)
//  CREDITS           16  downstream buffer depth in phits; also reset credit value
//  TOKEN_DECIMATION   4  credits returned per token toggle; CREDITS % TOKEN_DECIMATION == 0
// PORTS
//  clk           in   1                    single clock, rising edge
//  rst           in   1                    asynchronous, active-high reset
//  core_data_i   in   CORE_W               word to transmit
//  core_valid_i  in   1                    word valid
//  core_ready_o  out  1                    word accepted when core_valid_i & core_ready_o
//  io_data_o     out  CHANNEL_W            registered phit
//  io_valid_o    out  1                    registered phit valid, one cycle per phit
//  io_token_i    in   1                    toggle-encoded credit return, asynchronous to clk
//  credits_o     out  $clog2(CREDITS+1)    current credit count
//  credit_err_o  out  1                    sticky: credit return would exceed CREDITS
// BEHAVIOUR
//  Reset (async): state IDLE, credits_o=CREDITS, io_valid_o=0, io_data_o=0, credit_err_o=0,
//   phit index 0, token sync/prev flops 0. Reset mid-word drops the partial word with no further phits.
//  FSM: IDLE -> SEND on accept. SEND issues phit[idx] in any cycle with credits>0.
//   Issuing the last phit with no new accept in that cycle -> IDLE; with a new accept -> stays SEND, idx=0.
//  core_ready_o = (state==IDLE) | (state==SEND & idx==PHITS-1 & credits>0); combinational, no dependence on core_valid_i.
//  Accept loads the hold register. First phit is issued the next cycle when credits allow, so it appears on
//   io_data_o/io_valid_o 2 cycles after accept. Later phits follow one per cycle while credits>0.
//  No credit: no issue, io_valid_o=0, hold register and idx frozen; io_data_o keeps its last value.
//  Token: 2-flop synchroniser plus prev flop. Either edge of the synchronised signal = one return.
//   credits_o rises 3 cycles after an io_token_i toggle.
//  Credit update: next = credits - issue + (ret ? TOKEN_DECIMATION : 0).
//   Simultaneous issue and return are netted in a single cycle.
//   If next > CREDITS: saturate at CREDITS and set credit_err_o, which holds until reset.
//   Credits never go below 0 (issue requires credits>0).
// CONFIGURATION
//  LINK_UP_STATS_EN defined: adds output stat_phits_o [15:0], counting issued phits (wraps at 0xFFFF->0, reset 0).
//  LINK_UP_STATS_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package bsg_link_up_pkg: localparam PHITS=CORE_W/CHANNEL_W, IDX_W=$clog2(PHITS) (min 1),
//   typedef enum {UP_IDLE, UP_SEND} up_state_e, credit width function.
//  Sub-module bsg_link_token_edge: 2-flop sync + toggle detect, outputs 1-cycle ret pulse.
// TESTING (CORE_W=32, CHANNEL_W=16, CREDITS=16, TOKEN_DECIMATION=4)
//  Reset release, no traffic -> credits_o=16, io_valid_o=0, core_ready_o=1, credit_err_o=0.
//  Accept 0xDEADBEEF at cycle N -> io_data_o=0xBEEF valid at N+2, 0xDEAD at N+3; credits_o=14; IDLE after.
//  8 back-to-back words -> 16 contiguous phits, credits_o=0, core_ready_o=0, io_valid_o=0;
//   one token toggle -> credits_o=4 three cycles later, transmission resumes.
//  credits_o=5, phit issued in the same cycle as the ret pulse -> credits_o=8 next cycle.
//  Token toggle at credits_o=16 -> credits_o stays 16, credit_err_o=1 and held until rst.
//  rst asserted after phit 0 of a word -> io_valid_o=0 immediately, no phit 1, credits_o=16, core_ready_o=1.

Source files
------------

// File: rtl/bsg_link_up_pkg.sv
// Shared types and sizing helpers for the credit-based upstream link stage.
package bsg_link_up_pkg;

   localparam int UP_CORE_W    = 32;
   localparam int UP_CHANNEL_W = 16;
   localparam int PHITS        = UP_CORE_W / UP_CHANNEL_W;
   localparam int IDX_W        = (PHITS > 1) ? $clog2(PHITS) : 1;

   typedef enum logic {
      UP_IDLE,
      UP_SEND
   } up_state_e;

   // Number of phits a core word is split into.
   function automatic int phits_f(input int core_w, input int channel_w);
      return core_w / channel_w;
   endfunction

   // Width of the phit index, never narrower than one bit.
   function automatic int idx_w_f(input int phits);
      return (phits > 1) ? $clog2(phits) : 1;
   endfunction

   // Width needed to hold a credit count from 0 up to and including credits.
   function automatic int credit_w_f(input int credits);
      return (credits > 0) ? $clog2(credits + 1) : 1;
   endfunction

endpackage

// File: rtl/bsg_link_token_edge.sv
// Brings the toggle-encoded credit token into the clk domain and turns every
// change of the synchronised level into a single-cycle return pulse.
module bsg_link_token_edge (
   input  logic clk,
   input  logic rst,
   input  logic token_i,
   output logic ret_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Two-flop synchroniser followed by a history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written with non-blocking assignments so the
      // chain shifts by exactly one stage per clock regardless of statement order.
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= token_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Rising and falling edges both represent one credit return.
   assign ret_o = sync2_q ^ prev_q;

endmodule

// File: rtl/bsg_link_credit_upstream.sv
// Core-side transmit stage: accepts core words, serialises them LSB phit first
// and drives them onto the link under credit-based flow control.
// Optional macro LINK_UP_STATS_EN adds the stat_phits_o issued-phit counter.
module bsg_link_credit_upstream
   import bsg_link_up_pkg::*;
#(
   parameter int CORE_W           = UP_CORE_W,
   parameter int CHANNEL_W        = UP_CHANNEL_W,
   parameter int CREDITS          = 16,
   parameter int TOKEN_DECIMATION = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [CORE_W-1:0]                   core_data_i,
   input  logic                                core_valid_i,
   output logic                                core_ready_o,
   output logic [CHANNEL_W-1:0]                io_data_o,
   output logic                                io_valid_o,
   input  logic                                io_token_i,
   output logic [credit_w_f(CREDITS)-1:0]      credits_o,
`ifdef LINK_UP_STATS_EN
   output logic [15:0]                         stat_phits_o,
`endif
   output logic                                credit_err_o
);

   localparam int P  = phits_f(CORE_W, CHANNEL_W);
   localparam int IW = idx_w_f(P);
   localparam int CW = credit_w_f(CREDITS);
   localparam int SW = CW + 1;

   up_state_e          state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CORE_W-1:0]  hold_q;
   logic [CW-1:0]      credits_q;
   logic               err_q;
   logic [CHANNEL_W-1:0] io_data_q;
   logic               io_valid_q;
   logic               ret;
   logic               have_credit;
   logic               last_phit;
   logic               accept;
   logic               issue;
   logic [SW-1:0]      credit_sum;

   bsg_link_token_edge u_token_edge (
      .clk     (clk),
      .rst     (rst),
      .token_i (io_token_i),
      .ret_o   (ret)
   );

   assign have_credit  = (credits_q != '0);
   assign last_phit    = (idx_q == IW'(P - 1));
   assign core_ready_o = (state_q == UP_IDLE) | ((state_q == UP_SEND) & last_phit & have_credit);
   assign accept       = core_valid_i & core_ready_o;
   assign issue        = (state_q == UP_SEND) & have_credit;

   // Next-state and phit index: advance only on an issued phit, restart on a chained accept.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         UP_IDLE: begin
            if (accept) begin
               state_d = UP_SEND;
               idx_d   = '0;
            end
         end
         UP_SEND: begin
            if (issue) begin
               if (last_phit) begin
                  idx_d   = '0;
                  state_d = accept ? UP_SEND : UP_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = UP_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // FSM state and phit index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UP_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Hold register captures the accepted word for serialisation.
   // NOTE: pure datapath storage is left without reset; it is only read after an accept loads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_q <= core_data_i;
      end
   end

   // Registered link outputs; data keeps its last value while no phit is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_valid_q <= 1'b0;
         io_data_q  <= '0;
      end else begin
         io_valid_q <= issue;
         if (issue) begin
            io_data_q <= hold_q[idx_q*CHANNEL_W +: CHANNEL_W];
         end
      end
   end

   // Net issue and return in one step; headroom bit exposes overflow past CREDITS.
   always_comb begin
      credit_sum = SW'(credits_q) - SW'(issue) + (ret ? SW'(TOKEN_DECIMATION) : SW'(0));
   end

   // Credit counter with saturation and a sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits_q <= CW'(CREDITS);
         err_q     <= 1'b0;
      end else if (credit_sum > SW'(CREDITS)) begin
         credits_q <= CW'(CREDITS);
         err_q     <= 1'b1;
      end else begin
         credits_q <= credit_sum[CW-1:0];
      end
   end

`ifdef LINK_UP_STATS_EN
   logic [15:0] stat_q;

   // Free-running count of issued phits, wrapping at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else if (issue) begin
         stat_q <= stat_q + 16'd1;
      end
   end

   assign stat_phits_o = stat_q;
`endif

   assign io_data_o    = io_data_q;
   assign io_valid_o   = io_valid_q;
   assign credits_o    = credits_q;
   assign credit_err_o = err_q;

endmodule

// File: tb/tb_bsg_link_credit_upstream.sv
// Self-checking bench for bsg_link_credit_upstream (32/16/16/4 configuration).
// The reference model tracks outstanding phits as a queue and credits as plain
// arithmetic; token returns mature three cycles after the toggle is driven.
module tb_bsg_link_credit_upstream;

   logic        clk;
   logic        rst;
   logic [31:0] core_data_i;
   logic        core_valid_i;
   logic        core_ready_o;
   logic [15:0] io_data_o;
   logic        io_valid_o;
   logic        io_token_i;
   logic [4:0]  credits_o;
   logic        credit_err_o;
`ifdef LINK_UP_STATS_EN
   logic [15:0] stat_phits_o;
`endif

   bsg_link_credit_upstream #(
      .CORE_W           (32),
      .CHANNEL_W        (16),
      .CREDITS          (16),
      .TOKEN_DECIMATION (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .core_data_i  (core_data_i),
      .core_valid_i (core_valid_i),
      .core_ready_o (core_ready_o),
      .io_data_o    (io_data_o),
      .io_valid_o   (io_valid_o),
      .io_token_i   (io_token_i),
      .credits_o    (credits_o),
`ifdef LINK_UP_STATS_EN
      .stat_phits_o (stat_phits_o),
`endif
      .credit_err_o (credit_err_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [15:0] q_phits[$];
   int          tog_due[$];
   int          cyc;
   int          exp_credits;
   bit          exp_err;
   bit          exp_ready;
   bit          exp_valid;
   logic [15:0] exp_data;
   int          exp_stat;
   bit          obs_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      q_phits.delete();
      tog_due.delete();
      exp_credits = 16;
      exp_err     = 1'b0;
      exp_valid   = 1'b0;
      exp_data    = 16'h0;
      exp_stat    = 0;
   endtask

   // Hold reset for two cycles; leaves time at #1 after a rising edge.
   task automatic apply_reset();
      rst          = 1'b1;
      core_valid_i = 1'b0;
      core_data_i  = 32'h0;
      io_token_i   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock cycle: drive inputs, predict ready, advance the model across the edge.
   task automatic step(input bit v, input logic [31:0] d, input bit tog);
      int  ret;
      int  sum;
      bit  acc;
      bit  iss;
      core_valid_i = v;
      core_data_i  = d;
      if (tog) begin
         io_token_i = ~io_token_i;
         tog_due.push_back(cyc + 3);
      end
      exp_ready = (q_phits.size() == 0) || (q_phits.size() == 1 && exp_credits > 0);
      acc = v && exp_ready;
      @(negedge clk);
      obs_ready = core_ready_o;
      @(posedge clk);
      cyc++;
      iss = (q_phits.size() > 0) && (exp_credits > 0);
      exp_valid = iss;
      if (iss) begin
         exp_data = q_phits.pop_front();
         exp_stat = (exp_stat + 1) % 65536;
      end
      ret = 0;
      for (int j = tog_due.size() - 1; j >= 0; j--) begin
         if (tog_due[j] == cyc) begin
            ret++;
            tog_due.delete(j);
         end
      end
      sum = exp_credits - (iss ? 1 : 0) + 4 * ret;
      if (sum > 16) begin
         sum     = 16;
         exp_err = 1'b1;
      end
      exp_credits = sum;
      if (acc) begin
         q_phits.push_back(d[15:0]);
         q_phits.push_back(d[31:16]);
      end
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (int'(credits_o) != 16) begin n_fail++; $display("FAIL reset_credits got %0d exp 16", credits_o); end
      n_checks++;
      if (io_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", io_valid_o); end
      n_checks++;
      if (core_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", core_ready_o); end
      n_checks++;
      if (credit_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", credit_err_o); end
      n_checks++;
      if (io_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", io_data_o); end
   endtask

   task automatic test_single_word();
      apply_reset();
      step(1'b1, 32'hDEADBEEF, 1'b0);              // cycle N: accept
      n_checks++;
      if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept_ready got %b exp 1", obs_ready); end
      n_checks++;
      if (io_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_n1_valid got %b exp 0", io_valid_o); end
      step(1'b0, 32'h0, 1'b0);                     // N+2
      n_checks++;
      if (io_valid_o !== 1'b1 || io_data_o !== 16'hBEEF) begin
         n_fail++; $display("FAIL single_phit0 got v=%b d=%h exp v=1 d=beef", io_valid_o, io_data_o);
      end
      step(1'b0, 32'h0, 1'b0);                     // N+3
      n_checks++;
      if (io_valid_o !== 1'b1 || io_data_o !== 16'hDEAD) begin
         n_fail++; $display("FAIL single_phit1 got v=%b d=%h exp v=1 d=dead", io_valid_o, io_data_o);
      end
      n_checks++;
      if (int'(credits_o) != 14) begin n_fail++; $display("FAIL single_credits got %0d exp 14", credits_o); end
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (io_valid_o !== 1'b0 || core_ready_o !== 1'b1 || io_data_o !== 16'hDEAD) begin
         n_fail++; $display("FAIL single_idle got v=%b r=%b d=%h exp v=0 r=1 d=dead", io_valid_o, core_ready_o, io_data_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[9];
      logic [31:0] cur;
      int acc = 0, nvalid = 0, first = -1, last = -1, bad = 0;
      logic [15:0] want;
      apply_reset();
      for (int i = 0; i < 9; i++) w[i] = $urandom;
      for (int i = 0; i < 30; i++) begin
         step(acc < 9, (acc < 9) ? w[acc] : 32'h0, 1'b0);
         if (acc < 9 && obs_ready) acc++;
         if (io_valid_o) begin
            cur  = w[nvalid / 2];
            want = (nvalid % 2 == 0) ? cur[15:0] : cur[31:16];
            if (io_data_o !== want) bad++;
            if (first < 0) first = i;
            last = i;
            nvalid++;
         end
      end
      n_checks++;
      if (acc != 9 || nvalid != 16 || last - first + 1 != 16) begin
         n_fail++; $display("FAIL b2b_stream got acc=%0d phits=%0d span=%0d exp 9/16/16", acc, nvalid, last - first + 1);
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_data got %0d bad phits exp 0", bad); end
      n_checks++;
      if (int'(credits_o) != 0 || io_valid_o !== 1'b0 || core_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_stall got c=%0d v=%b r=%b exp 0/0/0", credits_o, io_valid_o, core_ready_o);
      end
      step(1'b0, 32'h0, 1'b1);                     // toggle driven in cycle k
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (int'(credits_o) != 0) begin n_fail++; $display("FAIL b2b_early_credit got %0d exp 0", credits_o); end
      step(1'b0, 32'h0, 1'b0);                     // k+3
      n_checks++;
      if (int'(credits_o) != 4 || io_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_token got c=%0d v=%b exp 4/0", credits_o, io_valid_o);
      end
      step(1'b0, 32'h0, 1'b0);
      cur = w[8];
      n_checks++;
      if (io_valid_o !== 1'b1 || io_data_o !== cur[15:0] || int'(credits_o) != 3) begin
         n_fail++; $display("FAIL b2b_resume got v=%b d=%h c=%0d exp 1/%h/3", io_valid_o, io_data_o, credits_o, cur[15:0]);
      end
   endtask

   task automatic test_netting();
      bit done = 1'b0;
      int t_tog = -100;
      bit tg;
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         tg = !done && exp_credits == 7;
         step(1'b1, $urandom, tg);
         if (tg) begin done = 1'b1; t_tog = i; end
         if (i == t_tog + 1) begin
            n_checks++;
            if (int'(credits_o) != 5) begin n_fail++; $display("FAIL net_pre got %0d exp 5", credits_o); end
         end
         if (i == t_tog + 2) begin
            n_checks++;
            if (int'(credits_o) != 8 || io_valid_o !== 1'b1) begin
               n_fail++; $display("FAIL net_same_cycle got c=%0d v=%b exp 8/1", credits_o, io_valid_o);
            end
         end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (credit_err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", credit_err_o); end
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (int'(credits_o) != 16 || credit_err_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sat got c=%0d e=%b exp 16/1", credits_o, credit_err_o);
      end
      step(1'b1, 32'h0BAD_F00D, 1'b0);
      repeat (5) step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (int'(credits_o) != 14 || credit_err_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_sticky got c=%0d e=%b exp 14/1", credits_o, credit_err_o);
      end
      apply_reset();
      #1;
      n_checks++;
      if (credit_err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", credit_err_o); end
   endtask

   task automatic test_reset_mid_word();
      int leaked = 0;
      apply_reset();
      step(1'b1, 32'h1234_5678, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (io_valid_o !== 1'b1 || io_data_o !== 16'h5678) begin
         n_fail++; $display("FAIL mid_phit0 got v=%b d=%h exp 1/5678", io_valid_o, io_data_o);
      end
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (io_valid_o !== 1'b0 || int'(credits_o) != 16 || core_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL mid_async got v=%b c=%0d r=%b exp 0/16/1", io_valid_o, credits_o, core_ready_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b0);
         if (io_valid_o !== 1'b0) leaked++;
      end
      n_checks++;
      if (leaked != 0 || int'(credits_o) != 16 || core_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL mid_after got leaks=%0d c=%0d r=%b exp 0/16/1", leaked, credits_o, core_ready_o);
      end
   endtask

   task automatic test_random();
      bit tg;
      int errs = 0;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         tg = (exp_credits + 4 * tog_due.size() + 4 <= 16) && ($urandom_range(0, 5) == 0);
         step($urandom_range(0, 1) == 1, $urandom, tg);
         n_checks++;
         if (obs_ready !== exp_ready || io_valid_o !== exp_valid || io_data_o !== exp_data ||
             int'(credits_o) != exp_credits || credit_err_o !== exp_err) begin
            n_fail++;
            errs++;
            if (errs <= 10) begin
               $display("FAIL rand_cycle%0d got r=%b v=%b d=%h c=%0d e=%b exp r=%b v=%b d=%h c=%0d e=%b",
                        i, obs_ready, io_valid_o, io_data_o, credits_o, credit_err_o,
                        exp_ready, exp_valid, exp_data, exp_credits, exp_err);
            end
         end
      end
`ifdef LINK_UP_STATS_EN
      n_checks++;
      if (int'(stat_phits_o) != exp_stat) begin
         n_fail++; $display("FAIL rand_stats got %0d exp %0d", stat_phits_o, exp_stat);
      end
`endif
   endtask

   initial begin
      rst          = 1'b1;
      core_valid_i = 1'b0;
      core_data_i  = 32'h0;
      io_token_i   = 1'b0;
      cyc          = 0;
      model_reset();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_netting();
      test_overflow();
      test_reset_mid_word();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
